wb_commit_unit: RTL

- Write-back (W) stage of the 5-stage MIPS pipeline; it is the writer side that drives the register file's write port (A3/WD/RF_wr plus PC/Instr for the commit trace).
- Holds the M->W pipeline register and performs load byte/half extension.
- Merges late results from the multiply/divide unit through a 1-deep pending buffer with a valid/ready handshake.
- Exports W-stage forwarding and pending-write info to the hazard unit.

---
 rtl/wb_commit_unit_pkg.sv | 25 ++
 rtl/wb_commit_unit_load_ext.sv | 30 +++
 rtl/wb_commit_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/wb_commit_unit_pkg.sv
// Shared encodings and default widths for the write-back commit unit.
package wb_commit_unit_pkg;

    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 5;
    localparam int CNT_W_DEF = 32;

    localparam int PC8_OFFSET = 8;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_H  = 3'd1,
        LD_HU = 3'd2,
        LD_B  = 3'd3,
        LD_BU = 3'd4
    } ld_type_e;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_PC8  = 2'd2,
        SEL_RSVD = 2'd3
    } res_sel_e;

endpackage

// File: rtl/wb_commit_unit_load_ext.sv
// Load lane selection and sign/zero extension for little-endian byte lanes.
module load_extender
    import wb_commit_unit_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] raw_i,
    input  logic [1:0]    addr_lo_i,
    input  logic [2:0]    ldtype_i,
    output logic [DW-1:0] data_o
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        // Halfword loads ignore addr_lo[0]; misalignment is handled upstream.
        half_v = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
        byte_v = raw_i[{addr_lo_i, 3'b000} +: 8];
        data_o = raw_i;
        case (ldtype_i)
            LD_H:    data_o = {{(DW-16){half_v[15]}}, half_v};
            LD_HU:   data_o = {{(DW-16){1'b0}}, half_v};
            LD_B:    data_o = {{(DW-8){byte_v[7]}}, byte_v};
            LD_BU:   data_o = {{(DW-8){1'b0}}, byte_v};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Write-back stage: M->W register, result mux, and a 1-deep MDU pending buffer.
// Optional COMMIT_TRACE_EN prints each RF write and the committed instruction word in binary.
module wb_commit_unit
    import wb_commit_unit_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m_valid,
    input  logic [AW-1:0]    m_dst,
    input  logic [1:0]       m_sel,
    input  logic [2:0]       m_ldtype,
    input  logic [1:0]       m_addr_lo,
    input  logic [DW-1:0]    m_alu,
    input  logic [DW-1:0]    m_mem,
    input  logic [DW-1:0]    m_pc,
    input  logic [DW-1:0]    m_instr,
    input  logic             mdu_valid,
    output logic             mdu_ready,
    input  logic [AW-1:0]    mdu_dst,
    input  logic [DW-1:0]    mdu_data,
    input  logic [DW-1:0]    mdu_pc,
    output logic             rf_wr,
    output logic [AW-1:0]    rf_a3,
    output logic [DW-1:0]    rf_wd,
    output logic [DW-1:0]    rf_pc,
    output logic [DW-1:0]    rf_instr,
    output logic             pend_valid,
    output logic [AW-1:0]    pend_dst,
    output logic [CNT_W-1:0] retired
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] dst;
        logic [1:0]    sel;
        logic [2:0]    ldtype;
        logic [1:0]    addr_lo;
        logic [DW-1:0] alu;
        logic [DW-1:0] mem;
        logic [DW-1:0] pc;
        logic [DW-1:0] instr;
    } w_reg_t;

    w_reg_t w_q, w_d;

    logic             pend_valid_q, pend_valid_d;
    logic [AW-1:0]    pend_dst_q, pend_dst_d;
    logic [DW-1:0]    pend_data_q, pend_data_d;
    logic [DW-1:0]    pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [DW-1:0]    load_data;
    logic [DW-1:0]    w_result;
    logic             wp;

    always_comb begin
        w_d         = '0;
        w_d.valid   = m_valid;
        w_d.dst     = m_dst;
        w_d.sel     = m_sel;
        w_d.ldtype  = m_ldtype;
        w_d.addr_lo = m_addr_lo;
        w_d.alu     = m_alu;
        w_d.mem     = m_mem;
        w_d.pc      = m_pc;
        w_d.instr   = m_instr;
    end

    load_extender #(.DW(DW)) u_load_ext (
        .raw_i     (w_q.mem),
        .addr_lo_i (w_q.addr_lo),
        .ldtype_i  (w_q.ldtype),
        .data_o    (load_data)
    );

    always_comb begin
        w_result = w_q.alu;
        case (w_q.sel)
            SEL_LOAD: w_result = load_data;
            SEL_PC8:  w_result = w_q.pc + DW'(PC8_OFFSET);
            default:  w_result = w_q.alu;
        endcase
    end

    assign wp = w_q.valid && (w_q.dst != '0);

    // The pipeline owns the write port; the pending MDU result only uses bubbles.
    always_comb begin
        rf_wr    = 1'b0;
        rf_a3    = '0;
        rf_wd    = '0;
        rf_pc    = '0;
        rf_instr = '0;
        if (wp) begin
            rf_wr    = 1'b1;
            rf_a3    = w_q.dst;
            rf_wd    = w_result;
            rf_pc    = w_q.pc;
            rf_instr = w_q.instr;
        end else if (pend_valid_q && (pend_dst_q != '0)) begin
            rf_wr    = 1'b1;
            rf_a3    = pend_dst_q;
            rf_wd    = pend_data_q;
            rf_pc    = pend_pc_q;
        end
    end

    // MDU handshake: a transfer happens on any edge where mdu_valid && mdu_ready;
    // the offerer holds dst/data/pc stable until then. Ready is low while full.
    assign mdu_ready = !pend_valid_q;

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_dst_d   = pend_dst_q;
        pend_data_d  = pend_data_q;
        pend_pc_d    = pend_pc_q;
        if (pend_valid_q) begin
            // Drains in a bubble, or is overwritten by a younger pipeline write (WAW).
            if (!wp || (w_q.dst == pend_dst_q)) begin
                pend_valid_d = 1'b0;
            end
        end else if (mdu_valid) begin
            pend_valid_d = 1'b1;
            pend_dst_d   = mdu_dst;
            pend_data_d  = mdu_data;
            pend_pc_d    = mdu_pc;
        end
    end

    assign retired_d = retired_q + (rf_wr ? CNT_W'(1) : CNT_W'(0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q          <= '0;
            pend_valid_q <= 1'b0;
            pend_dst_q   <= '0;
            pend_data_q  <= '0;
            pend_pc_q    <= '0;
            retired_q    <= '0;
        end else begin
            w_q          <= w_d;
            pend_valid_q <= pend_valid_d;
            pend_dst_q   <= pend_dst_d;
            pend_data_q  <= pend_data_d;
            pend_pc_q    <= pend_pc_d;
            retired_q    <= retired_d;
        end
    end

    assign pend_valid = pend_valid_q;
    assign pend_dst   = pend_dst_q;
    assign retired    = retired_q;

`ifdef COMMIT_TRACE_EN
    always @(posedge clk) begin
        if (rf_wr) begin
            $display("%0t@%08h: $%0d <= %08h", $time, rf_pc, rf_a3, rf_wd);
            $display("%b", rf_instr);
        end
    end
`endif

endmodule
